wide_add_sequencer: RTL
=======================

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 Parameter: WORDS, default 4, number of 16-bit chunks; operand width W = 16*WORDS; legal range 2..8.
REQ-002 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  requester presents an operation.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry-in for chunk 0.
REQ-010 out_valid  output  1  result and flags are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 sum  output  W  registered result.
REQ-013 cout  output  1  carry-out of the top chunk.
REQ-014 ovf  output  1  signed two's-complement overflow of the full W-bit operation.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 Block SHALL contain exactly one 16-bit add slice (a16 + b16 + c -> 16-bit sum, carry-out) and reuse it once per cycle; no W-bit adder.
REQ-017 FSM states: IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-018 IDLE: on in_valid && in_ready, latch a, b and cin, clear chunk index to 0, clear sum, go to RUN; otherwise stay.
REQ-019 RUN: each cycle, add chunk[idx] of latched A and B with the carry register, write the 16 sum bits into sum[16*idx +: 16], load the slice carry-out into the carry register, and increment idx.
REQ-020 RUN: on the cycle idx == WORDS-1, go to DONE; cout = final carry; ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the effective B operand.
REQ-021 Latency: out_valid SHALL rise exactly WORDS clock edges after the accepting edge.
REQ-022 DONE: hold sum, cout and ovf stable until out_valid && out_ready; on that edge go to IDLE. No new accept occurs in the same cycle.
REQ-023 Minimum initiation interval is WORDS+2 cycles when out_ready is held high.
REQ-024 in_valid, a, b and cin SHALL be ignored outside IDLE; changing operands after the accept SHALL NOT affect the result.
REQ-025 Wrap-around: the W-bit result is modulo 2^W; the carry out of bit W-1 appears only on cout.
REQ-026 The chunk index SHALL be ceil(log2(WORDS)) bits wide and SHALL NOT increment past WORDS-1.

Reset
REQ-027 rst SHALL force state IDLE, idx 0, carry register 0, sum 0, cout 0, ovf 0; as a result out_valid = 0, busy = 0 and in_ready = 1 on the first cycle after reset.
REQ-028 rst asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; rst has priority over all other inputs.

Configuration
REQ-029 Macro WIDE_ADD_SUB_EN: when defined, add port "sub  input  1", latched at accept. When sub = 1, B is inverted per chunk and the initial carry is forced to 1 (cin is ignored), so cout = 1 means no borrow.
REQ-030 Without WIDE_ADD_SUB_EN: port sub is absent and the block performs A + B + cin only; behaviour is otherwise identical.

Verification (WORDS = 4)
REQ-031 a = 0xFFFF_FFFF_FFFF_FFFF, b = 1, cin = 0 -> sum = 0, cout = 1, ovf = 0; out_valid exactly 4 edges after accept.
REQ-032 a = 0x0000_0000_0000_FFFF, b = 1, cin = 0 -> sum = 0x0000_0000_0001_0000, cout = 0 (carry chained chunk 0 -> 1).
REQ-033 a = 0x7FFF_FFFF_FFFF_FFFF, b = 0, cin = 1 -> sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0.
REQ-034 Result pending, out_ready low for 5 cycles while in_valid pulses with new operands -> sum stable, in_ready = 0, pulses ignored; out_ready high -> IDLE next edge.
REQ-035 rst asserted on the second RUN cycle -> next cycle state IDLE, in_ready = 1, out_valid = 0, sum = 0; no out_valid pulse follows.
REQ-036 With WIDE_ADD_SUB_EN: sub = 1, a = 5, b = 7 -> sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0; a = 7, b = 5 -> sum = 2, cout = 1.

Source files
------------

// File: rtl/wide_add_if.sv
// wide_add_if: request/response bundle for wide_add_sequencer.
// The subtract-mode signal 'sub' exists only when WIDE_ADD_SUB_EN is defined.
interface wide_add_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef WIDE_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  // Requester / consumer side
  modport master (
    output in_valid, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: W = 16*WORDS bit add built from a single 16-bit slice,
// one chunk per cycle from chunk 0 upward, with valid/ready on both sides.
// Optional feature macro: WIDE_ADD_SUB_EN (adds 'sub'; subtract = A + ~B + 1).
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic      clk,
  input  logic      rst,
  wide_add_if.slave bus
);
  localparam int W = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic             sub_mode;
  logic             start_carry;
  logic [IDX_W+3:0] base;
  logic [15:0]      chunk_a;
  logic [15:0]      chunk_b;
  logic [15:0]      slice_s;
  logic             slice_c;
  logic             sign_a;
  logic             sign_b;

`ifdef WIDE_ADD_SUB_EN
  logic sub_q, sub_d;
  assign sub_mode    = sub_q;
  // Subtraction forces the +1 of the two's-complement negate; cin is ignored.
  assign start_carry = bus.sub ? 1'b1 : bus.cin;
`else
  assign sub_mode    = 1'b0;
  assign start_carry = bus.cin;
`endif

  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (idx_q == LAST_IDX);

  // The one shared 16-bit slice; B chunk is inverted in subtract mode.
  assign base                = {idx_q, 4'b0000};
  assign chunk_a             = a_q[base +: 16];
  assign chunk_b             = b_q[base +: 16] ^ {16{sub_mode}};
  assign {slice_c, slice_s}  = {1'b0, chunk_a} + {1'b0, chunk_b} + {16'b0, carry_q};

  // Sign bits of A and of the effective B operand, for overflow on the top chunk.
  assign sign_a = a_q[W-1];
  assign sign_b = b_q[W-1] ^ sub_mode;

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == RUN) || (state_q == DONE);
  end

  // Datapath next values: latch on accept, one chunk per RUN cycle, hold otherwise
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef WIDE_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      sum_d   = '0;
      idx_d   = '0;
      carry_d = start_carry;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub_d   = bus.sub;
`endif
    end else if (state_q == RUN) begin
      sum_d[base +: 16] = slice_s;
      carry_d           = slice_c;
      if (last) begin
        // Index stays on the top chunk; flags are taken from the final slice.
        cout_d = slice_c;
        ovf_d  = (sign_a == sign_b) && (slice_s[15] != sign_a);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Result and sequencing registers (cleared by reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Latched operands (data only, no reset needed)
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
`ifdef WIDE_ADD_SUB_EN
    sub_q <= sub_d;
`endif
  end
endmodule
